// File: rtl/dcache_ctrl_if.sv
// Request/response bus shared by the processor side and the memory side of the
// data cache: master issues addr/wdata/rw/en, slave returns rdata and miss (stall).
interface dcache_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rw;
  logic                  en;
  logic                  miss;

  modport master (
    output addr, wdata, rw, en,
    input  rdata, miss
  );

  modport slave (
    input  addr, wdata, rw, en,
    output rdata, miss
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with
// one-word lines; read hits complete combinationally, misses and writes stall.
module dcache_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Flush,
  dcache_ctrl_if.slave  cpu,
  dcache_ctrl_if.master mem
);
  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t state, state_nxt;

  logic [LINES-1:0]      valid;
  logic [TAG_W-1:0]      tag_arr  [LINES];
  logic [DATA_WIDTH-1:0] data_arr [LINES];

  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_data;

  logic [INDEX_BITS-1:0] req_idx, lat_idx;
  logic [TAG_W-1:0]      req_tag, lat_tag;
  logic                  req_hit, lat_hit, mem_done;

  assign req_idx  = cpu.addr[INDEX_BITS+1:2];
  assign req_tag  = cpu.addr[ADDR_WIDTH-1:INDEX_BITS+2];
  assign lat_idx  = lat_addr[INDEX_BITS+1:2];
  assign lat_tag  = lat_addr[ADDR_WIDTH-1:INDEX_BITS+2];
  assign req_hit  = valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign lat_hit  = valid[lat_idx] && (tag_arr[lat_idx] == lat_tag);
  assign mem_done = !mem.miss;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cpu.miss  = 1'b0;
    cpu.rdata = data_arr[req_idx];
    mem.en    = 1'b0;
    mem.rw    = 1'b0;
    mem.addr  = lat_addr;
    mem.wdata = lat_data;
    case (state)
      IDLE: begin
        if (cpu.en) begin
          if (cpu.rw) begin
            cpu.miss  = 1'b1;
            state_nxt = WRITE;
          end else if (!req_hit) begin
            cpu.miss  = 1'b1;
            state_nxt = FILL;
          end
        end
      end
      FILL: begin
        mem.en   = 1'b1;
        cpu.miss = 1'b1;
        if (mem_done) state_nxt = IDLE;
      end
      WRITE: begin
        mem.en   = 1'b1;
        mem.rw   = 1'b1;
        cpu.miss = 1'b1;
        if (mem_done) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Flush wins over a same-edge fill install: the line stays invalid.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                          valid <= '0;
    else if (Flush)                    valid <= '0;
    else if (state == FILL && mem_done) valid[lat_idx] <= 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (state == FILL && mem_done) begin
      tag_arr[lat_idx]  <= lat_tag;
      data_arr[lat_idx] <= mem.rdata;
    end else if (state == WRITE && mem_done && lat_hit) begin
      data_arr[lat_idx] <= lat_data;
    end
    if (state == IDLE && cpu.en) begin
      lat_addr <= cpu.addr;
      lat_data <= cpu.wdata;
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a latency-programmable memory responder.
module tb_dcache_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  always #5 clk = ~clk;

  dcache_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) cpu_if ();
  dcache_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_if ();

  dcache_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .INDEX_BITS(4)) dut (
    .Clk   (clk),
    .Rst   (rst_n),
    .Flush (flush),
    .cpu   (cpu_if),
    .mem   (mem_if)
  );

  logic [31:0] mem_arr [0:1023];
  int unsigned lat = 0;
  int unsigned mem_cnt = 0;
  int unsigned wr_cnt = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;
  int checks = 0;
  int errors = 0;

  // Memory stalls for 'lat' cycles after mem_en rises, then completes.
  assign mem_if.miss  = mem_if.en && (mem_cnt < lat);
  assign mem_if.rdata = mem_arr[mem_if.addr[11:2]];

  always @(posedge clk) begin
    if (!mem_if.en) mem_cnt <= 0;
    else if (mem_if.miss) mem_cnt <= mem_cnt + 1;
    else begin
      mem_cnt <= 0;
      if (mem_if.rw) begin
        wr_cnt     <= wr_cnt + 1;
        last_waddr <= mem_if.addr;
        last_wdata <= mem_if.wdata;
      end
    end
  end

  task automatic run_read(input logic [31:0] a, output int unsigned cyc, output logic [31:0] d);
    cpu_if.addr = a;
    cpu_if.rw   = 1'b0;
    cpu_if.en   = 1'b1;
    #1;
    cyc = 0;
    while (cpu_if.miss === 1'b1 && cyc < 50) begin
      cyc++;
      @(posedge clk); #1;
    end
    d = cpu_if.rdata;
    @(posedge clk); #1;
    cpu_if.en = 1'b0;
  endtask

  task automatic run_write(input logic [31:0] a, input logic [31:0] wd, output int unsigned cyc,
                           output logic seen, output logic srw, output logic [31:0] sa,
                           output logic [31:0] sd);
    cpu_if.addr  = a;
    cpu_if.wdata = wd;
    cpu_if.rw    = 1'b1;
    cpu_if.en    = 1'b1;
    #1;
    cyc = 0; seen = 1'b0; srw = 1'b0; sa = '0; sd = '0;
    while (cpu_if.miss === 1'b1 && cyc < 50) begin
      if (mem_if.en === 1'b1) begin
        seen = 1'b1; srw = mem_if.rw; sa = mem_if.addr; sd = mem_if.wdata;
      end
      cyc++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    cpu_if.en = 1'b0;
    cpu_if.rw = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    cpu_if.addr = 32'h40; cpu_if.wdata = '0; cpu_if.rw = 1'b0; cpu_if.en = 1'b1;
    #2;
    checks++; if (cpu_if.miss !== 1'b1) $display("FAIL reset_miss_en1: got %b expected 1", cpu_if.miss);
    checks++; if (mem_if.en !== 1'b0) $display("FAIL reset_mem_en: got %b expected 0", mem_if.en);
    if (cpu_if.miss !== 1'b1) errors++;
    if (mem_if.en !== 1'b0) errors++;
    cpu_if.en = 1'b0;
    #1;
    checks++;
    if (cpu_if.miss !== 1'b0) begin
      errors++; $display("FAIL reset_miss_en0: got %b expected 0", cpu_if.miss);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_read_miss();
    int unsigned cyc;
    logic [31:0] d;
    mem_arr[16] = 32'hDEAD_BEEF;
    lat = 2;
    run_read(32'h40, cyc, d);
    checks++; if (cyc != 4) begin errors++; $display("FAIL rd_miss_cycles: got %0d expected 4", cyc); end
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_miss_data: got %h expected deadbeef", d); end
    run_read(32'h40, cyc, d);
    checks++; if (cyc != 0) begin errors++; $display("FAIL rd_hit_cycles: got %0d expected 0", cyc); end
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_hit_data: got %h expected deadbeef", d); end
  endtask

  task automatic test_conflict();
    int unsigned cyc;
    logic [31:0] d;
    mem_arr[272] = 32'h1111_2222;
    run_read(32'h440, cyc, d);
    checks++; if (cyc != 4) begin errors++; $display("FAIL conf_440_cycles: got %0d expected 4", cyc); end
    checks++; if (d !== 32'h1111_2222) begin errors++; $display("FAIL conf_440_data: got %h expected 11112222", d); end
    run_read(32'h40, cyc, d);
    checks++; if (cyc != 4) begin errors++; $display("FAIL conf_40_cycles: got %0d expected 4", cyc); end
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL conf_40_data: got %h expected deadbeef", d); end
  endtask

  task automatic test_write();
    int unsigned cyc, wr0;
    logic seen, srw;
    logic [31:0] sa, sd, d;
    lat = 1;
    wr0 = wr_cnt;
    run_write(32'h40, 32'hCAFE_0001, cyc, seen, srw, sa, sd);
    checks++; if (cyc != 3) begin errors++; $display("FAIL wr_hit_cycles: got %0d expected 3", cyc); end
    checks++; if (seen !== 1'b1 || srw !== 1'b1) begin errors++; $display("FAIL wr_mem_en_rw: got en %b rw %b expected 1 1", seen, srw); end
    checks++; if (sa !== 32'h40) begin errors++; $display("FAIL wr_mem_addr: got %h expected 00000040", sa); end
    checks++; if (sd !== 32'hCAFE_0001) begin errors++; $display("FAIL wr_mem_wdata: got %h expected cafe0001", sd); end
    checks++; if (wr_cnt != wr0 + 1) begin errors++; $display("FAIL wr_mem_count: got %0d expected %0d", wr_cnt, wr0 + 1); end
    mem_arr[16] = 32'hCAFE_0001;
    run_read(32'h40, cyc, d);
    checks++; if (cyc != 0) begin errors++; $display("FAIL wr_then_rd_cycles: got %0d expected 0", cyc); end
    checks++; if (d !== 32'hCAFE_0001) begin errors++; $display("FAIL wr_then_rd_data: got %h expected cafe0001", d); end
    run_write(32'h80, 32'h1234_5678, cyc, seen, srw, sa, sd);
    checks++; if (cyc != 3) begin errors++; $display("FAIL wr_miss_cycles: got %0d expected 3", cyc); end
    checks++; if (sa !== 32'h80 || sd !== 32'h1234_5678) begin errors++; $display("FAIL wr_miss_mem: got %h/%h expected 00000080/12345678", sa, sd); end
    mem_arr[32] = 32'h1234_5678;
    run_read(32'h80, cyc, d);
    checks++; if (cyc != 3) begin errors++; $display("FAIL no_alloc_cycles: got %0d expected 3", cyc); end
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL no_alloc_data: got %h expected 12345678", d); end
  endtask

  task automatic test_flush();
    int unsigned cyc;
    logic [31:0] d;
    lat = 2;
    cpu_if.addr = 32'h40; cpu_if.rw = 1'b0; cpu_if.en = 1'b1;
    #1;
    cyc = 0;
    while (!(mem_if.en === 1'b1 && mem_if.miss === 1'b0) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (cyc >= 50) begin errors++; $display("FAIL flush_wait_fill: got %0d cycles expected fewer than 50", cyc); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (cpu_if.miss !== 1'b1) begin errors++; $display("FAIL flush_held_miss: got %b expected 1", cpu_if.miss); end
    checks++; if (mem_if.en !== 1'b0) begin errors++; $display("FAIL flush_idle_mem_en: got %b expected 0", mem_if.en); end
    run_read(32'h40, cyc, d);
    checks++; if (cyc != 4) begin errors++; $display("FAIL flush_refetch_cycles: got %0d expected 4", cyc); end
    checks++; if (d !== 32'hCAFE_0001) begin errors++; $display("FAIL flush_refetch_data: got %h expected cafe0001", d); end
    run_read(32'h40, cyc, d);
    checks++; if (cyc != 0) begin errors++; $display("FAIL flush_rehit_cycles: got %0d expected 0", cyc); end
  endtask

  task automatic test_reset_mid_fill();
    int unsigned cyc;
    logic [31:0] d;
    mem_arr[65] = 32'h0104_0104;
    lat = 3;
    cpu_if.addr = 32'h104; cpu_if.rw = 1'b0; cpu_if.en = 1'b1;
    @(posedge clk); #1;
    checks++; if (mem_if.en !== 1'b1) begin errors++; $display("FAIL rstfill_mem_en_before: got %b expected 1", mem_if.en); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_if.en !== 1'b0) begin errors++; $display("FAIL rstfill_mem_en_async: got %b expected 0", mem_if.en); end
    checks++; if (cpu_if.miss !== 1'b1) begin errors++; $display("FAIL rstfill_miss: got %b expected 1", cpu_if.miss); end
    cpu_if.en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    lat = 2;
    run_read(32'h40, cyc, d);
    checks++; if (cyc != 4) begin errors++; $display("FAIL rstfill_40_cycles: got %0d expected 4", cyc); end
    checks++; if (d !== 32'hCAFE_0001) begin errors++; $display("FAIL rstfill_40_data: got %h expected cafe0001", d); end
    run_read(32'h104, cyc, d);
    checks++; if (cyc != 4) begin errors++; $display("FAIL rstfill_104_cycles: got %0d expected 4", cyc); end
    checks++; if (d !== 32'h0104_0104) begin errors++; $display("FAIL rstfill_104_data: got %h expected 01040104", d); end
  endtask

  task automatic test_en_drop();
    int unsigned cyc, wr0;
    logic [31:0] d;
    lat = 2;
    wr0 = wr_cnt;
    cpu_if.addr = 32'h200; cpu_if.wdata = 32'hA5A5_A5A5; cpu_if.rw = 1'b1; cpu_if.en = 1'b1;
    #1;
    checks++; if (cpu_if.miss !== 1'b1) begin errors++; $display("FAIL endrop_req_miss: got %b expected 1", cpu_if.miss); end
    @(posedge clk); #1;
    cpu_if.en = 1'b0; cpu_if.rw = 1'b0;
    #1;
    checks++; if (mem_if.en !== 1'b1 || mem_if.rw !== 1'b1) begin errors++; $display("FAIL endrop_mem_active: got en %b rw %b expected 1 1", mem_if.en, mem_if.rw); end
    cyc = 0;
    while (wr_cnt == wr0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (wr_cnt != wr0 + 1) begin errors++; $display("FAIL endrop_write_done: got %0d expected %0d", wr_cnt, wr0 + 1); end
    checks++; if (last_waddr !== 32'h200 || last_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL endrop_write_val: got %h/%h expected 00000200/a5a5a5a5", last_waddr, last_wdata); end
    checks++; if (cpu_if.miss !== 1'b0) begin errors++; $display("FAIL endrop_done_miss: got %b expected 0", cpu_if.miss); end
    @(posedge clk); #1;
    checks++; if (mem_if.en !== 1'b0 || cpu_if.miss !== 1'b0) begin errors++; $display("FAIL endrop_idle: got en %b miss %b expected 0 0", mem_if.en, cpu_if.miss); end
    run_read(32'h40, cyc, d);
    checks++; if (cyc != 0) begin errors++; $display("FAIL endrop_rd_cycles: got %0d expected 0", cyc); end
    checks++; if (d !== 32'hCAFE_0001) begin errors++; $display("FAIL endrop_rd_data: got %h expected cafe0001", d); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_miss();
    test_conflict();
    test_write();
    test_flush();
    test_reset_mid_fill();
    test_en_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
